// File: rtl/window_fetcher.sv
// window_fetcher: raster sweep of 5x5 pixel windows, one memory read per window origin (FETCH_TIMEOUT_EN bounds the wait on ram_finish).
// Latency: 4 cycles per window from sampled ram_finish with win_ready held high.
// Backpressure: win_valid holds a window until win_ready; no memory request is issued meanwhile.
module window_fetcher #(
  parameter int STRIDE         = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            base_addr,
  input  logic [15:0]            img_width,
  input  logic [15:0]            img_height,
  output logic                   ram_enable,
  output logic                   ram_write,
  output logic [15:0]            ram_address,
  output logic [15:0]            ram_offset,
  input  logic                   ram_finish,
  input  logic [4:0][4:0][15:0]  ram_data,
  output logic [4:0][4:0][15:0]  win_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [15:0]            win_row,
  output logic [15:0]            win_col,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {IDLE, REQ, RELEASE, HOLD, ADVANCE, DONE} state_t;

  state_t      state;
  logic [15:0] row;
  logic [15:0] col;
  logic [15:0] width;
  logic [15:0] height;
  logic [15:0] row_addr;
  logic [15:0] pitch;

  logic [16:0] col_step;
  logic [16:0] row_step;
  logic        col_wrap;
  logic        row_end;
  logic [15:0] next_row_addr;

  // STRIDE rows of pitch, built from adds so no multiplier is needed
  function automatic logic [15:0] times_stride(input logic [15:0] v);
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < STRIDE; k++) acc = acc + v;
    return acc;
  endfunction

  assign col_step      = {1'b0, col} + 17'(STRIDE);
  assign row_step      = {1'b0, row} + 17'(STRIDE);
  assign col_wrap      = col_step > {1'b0, width - 16'd5};
  assign row_end       = row_step > {1'b0, height - 16'd5};
  assign next_row_addr = row_addr + pitch;
  assign ram_write     = 1'b0;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_enable  <= 1'b0;
      ram_address <= '0;
      ram_offset  <= '0;
      win_data    <= '0;
      win_valid   <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      row         <= '0;
      col         <= '0;
      width       <= '0;
      height      <= '0;
      row_addr    <= '0;
      pitch       <= '0;
`ifdef FETCH_TIMEOUT_EN
      error       <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            width       <= img_width;
            height      <= img_height;
            row         <= '0;
            col         <= '0;
            row_addr    <= base_addr;
            ram_address <= base_addr;
            ram_offset  <= img_width;
            pitch       <= times_stride(img_width);
`ifdef FETCH_TIMEOUT_EN
            error       <= 1'b0;
            tmo_cnt     <= '0;
`endif
            // An image smaller than one window yields no requests at all
            if (img_width < 16'd5 || img_height < 16'd5) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy       <= 1'b1;
              ram_enable <= 1'b1;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (ram_finish) begin
            win_data   <= ram_data;
            win_row    <= row;
            win_col    <= col;
            ram_enable <= 1'b0;
            state      <= RELEASE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            ram_enable <= 1'b0;
            error      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          win_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            state     <= ADVANCE;
          end
        end
        ADVANCE: begin
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (col_wrap) begin
            col <= '0;
            if (row_end) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row         <= row_step[15:0];
              row_addr    <= next_row_addr;
              ram_address <= next_row_addr;
              ram_enable  <= 1'b1;
              state       <= REQ;
            end
          end else begin
            col         <= col_step[15:0];
            ram_address <= ram_address + 16'(STRIDE);
            ram_enable  <= 1'b1;
            state       <= REQ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/window_fetcher.md
WINDOW_FETCHER -- requirements
Module: window_fetcher

Interface
REQ-001 Parameter: STRIDE, 1, column/row step between successive window origins; legal values 1..4.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, maximum cycles to wait for ram_finish (used only with FETCH_TIMEOUT_EN).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: start  in  1  one-cycle pulse; begins a sweep; ignored while busy=1.
REQ-006 Port: base_addr  in  16  word address of image pixel (0,0); sampled on accepted start.
REQ-007 Port: img_width / img_height  in  16 each  image dimensions in pixels; sampled on accepted start.
REQ-008 Port: ram_enable  out  1  memory request.
REQ-009 Port: ram_write  out  1  tied 0 (read-only).
REQ-010 Port: ram_address / ram_offset  out  16 each  window origin address / row pitch (= img_width).
REQ-011 Port: ram_finish  in  1  memory access complete.
REQ-012 Port: ram_data  in  5x5x16  window returned by memory, row-major [row][col].
REQ-013 Port: win_data  out  5x5x16  captured window to downstream conv stage.
REQ-014 Port: win_valid / win_ready  out / in  1 each  downstream handshake.
REQ-015 Port: win_row / win_col  out  16 each  origin coordinates of win_data.
REQ-016 Port: busy / done / error  out  1 each  sweep active / one-cycle sweep-complete pulse / sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, RELEASE, HOLD, ADVANCE, DONE.
REQ-018 IDLE: on start, latch inputs, clear row/col to 0, enter REQ; busy=1 from the next cycle; if img_width<5 or img_height<5, go directly to DONE (no memory request).
REQ-019 REQ: ram_enable=1, ram_address=base+row*img_width+col (mod 2^16, computed incrementally, no multiplier); on sampled ram_finish=1, capture ram_data into win_data and enter RELEASE.
REQ-020 RELEASE: ram_enable=0 for exactly one cycle (so memory clears its finish flag), then HOLD.
REQ-021 HOLD: win_valid=1; win_data/win_row/win_col stable; on win_valid&win_ready, enter ADVANCE; win_valid SHALL drop the following cycle.
REQ-022 ADVANCE: col+=STRIDE; if col+STRIDE>img_width-5, col=0 and row+=STRIDE; if row also exceeds img_height-5, enter DONE; else REQ. ADVANCE lasts one cycle.
REQ-023 DONE: done=1 for one cycle, busy=0, return to IDLE.
REQ-024 Window order SHALL be raster (row-major); count = (floor((W-5)/STRIDE)+1)*(floor((H-5)/STRIDE)+1).
REQ-025 Minimum per-window latency: 1 REQ cycle after finish + RELEASE + HOLD + ADVANCE = 4 cycles with ready held high.
REQ-026 ram_enable SHALL never be asserted outside REQ; ram_write SHALL always be 0.
REQ-027 ram_finish outside REQ SHALL be ignored.
REQ-028 start during busy SHALL NOT affect latched parameters or state.

Reset
REQ-029 On rst=1 at a rising edge: state=IDLE, ram_enable=0, ram_address=0, ram_offset=0, win_data=all 0, win_valid=0, win_row=0, win_col=0, busy=0, done=0, error=0.
REQ-030 Reset mid-sweep SHALL abort immediately; ram_enable is 0 in the cycle after the reset edge; no done pulse.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN: when defined, a counter runs in REQ; if ram_finish not seen within TIMEOUT_CYCLES cycles, drop ram_enable, set error=1 (sticky until rst or next accepted start), and go to DONE.
REQ-032 Without FETCH_TIMEOUT_EN: no counter; REQ waits indefinitely; error tied 0.

Verification
REQ-033 W=7,H=6,STRIDE=1,base=0x0100, finish 2 cycles after enable, ready=1 -> 6 windows, origins (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), addresses 0x0100,0x0101,0x0102,0x0107,0x0108,0x0109, ram_offset=7, one done pulse.
REQ-034 W=9,H=5,STRIDE=2, ready low 10 cycles on window 2 -> win_valid held, win_data/win_col=2 stable, no new ram_enable until ready; 3 windows total.
REQ-035 W=4,H=10 start -> done pulse within 2 cycles, ram_enable never asserted, zero windows.
REQ-036 rst asserted while in REQ on window 3 -> next cycle ram_enable=0, busy=0, win_valid=0; fresh start then completes normally.
REQ-037 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, ram_finish never asserted -> ram_enable drops after 8 cycles, error=1, done pulse; without macro -> busy remains 1.
REQ-038 start pulsed while busy with different base_addr -> ignored; address sequence unchanged.
